// File: rtl/zintack_if.sv
// Z80 interrupt-acknowledge bus bundle: CPU/controller signals in, acknowledge/vector/RET status out.
// ret_st exposes the RETI/RETN decoder state (1 = an ED prefix has just been fetched).
interface zintack_if;
  logic       m1_n;
  logic       iorq_n;
  logic       mreq_n;
  logic       rd_n;
  logic [7:0] din;
  logic       int_n;
  logic [7:0] im2vect;
  logic       intack;
  logic [7:0] dout;
  logic       dout_oe;
  logic       reti;
  logic       retn;
  logic       spur;
  logic       insvc;
  logic [2:0] depth;
  logic       ret_st;

  modport master (
    output m1_n, iorq_n, mreq_n, rd_n, din, int_n, im2vect,
    input  intack, dout, dout_oe, reti, retn, spur, insvc, depth, ret_st
  );

  modport slave (
    input  m1_n, iorq_n, mreq_n, rd_n, din, int_n, im2vect,
    output intack, dout, dout_oe, reti, retn, spur, insvc, depth, ret_st
  );
endinterface

// File: rtl/zintack.sv
// Z80 IM2 interrupt acknowledge: filtered INTA detection, vector drive, RETI/RETN decode
// and interrupt nesting depth tracking. All inputs are synchronous to clk.
module zintack (
  input logic      clk,
  input logic      res,
  zintack_if.slave bus
);
  typedef enum logic {ST_IDLE = 1'b0, ST_ED = 1'b1} ret_state_t;

  ret_state_t state;
  logic       cond_q;
  logic       in_fetch;
  logic       cap_v;
  logic [7:0] cap;

  logic inta_cond, qual, rise, fetch, fetch_end, fire_reti, fire_retn, dec;

  // INTA qualifies once the condition has been seen on two consecutive edges.
  assign inta_cond = !bus.m1_n && !bus.iorq_n;
  assign qual      = inta_cond && cond_q;
  assign rise      = qual && !bus.intack;

  // A fetch ends on the first edge rd_n is seen high after having been low in the fetch.
  assign fetch     = !bus.m1_n && !bus.mreq_n && !bus.rd_n;
  assign fetch_end = in_fetch && bus.rd_n;

  assign fire_reti = cap_v && (state == ST_ED) && (cap == 8'h4D);
  assign fire_retn = cap_v && (state == ST_ED) && (cap == 8'h45);
  assign dec       = fire_reti || fire_retn;

  always_ff @(posedge clk) begin
    if (res) begin
      cond_q      <= 1'b0;
      in_fetch    <= 1'b0;
      cap_v       <= 1'b0;
      cap         <= 8'h00;
      state       <= ST_IDLE;
      bus.intack  <= 1'b0;
      bus.dout    <= 8'h00;
      bus.dout_oe <= 1'b0;
      bus.spur    <= 1'b0;
      bus.reti    <= 1'b0;
      bus.retn    <= 1'b0;
      bus.depth   <= 3'd0;
    end else begin
      cond_q      <= inta_cond;
      bus.intack  <= qual;
      bus.dout_oe <= qual || bus.intack;
      bus.spur    <= rise && bus.int_n;
      if (rise) bus.dout <= bus.im2vect;

      if (fetch)        in_fetch <= 1'b1;
      else if (bus.rd_n) in_fetch <= 1'b0;
      cap_v <= fetch_end;
      if (fetch_end) cap <= bus.din;

      bus.reti <= fire_reti;
      bus.retn <= fire_retn;
      // The captured byte is decoded one edge after capture.
      if (cap_v) begin
        case (state)
          ST_IDLE: if (cap == 8'hED) state <= ST_ED;
          ST_ED:   state <= (cap == 8'hED) ? ST_ED : ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end

      if (rise && !dec && bus.depth != 3'd7)
        bus.depth <= bus.depth + 3'd1;
      else if (dec && !rise && bus.depth != 3'd0)
        bus.depth <= bus.depth - 3'd1;
    end
  end

  assign bus.insvc  = (bus.depth != 3'd0);
  assign bus.ret_st = (state == ST_ED);
endmodule

// File: tb/tb_zintack.sv
// Randomized plus directed bench for zintack against a cycle-level behavioural model
// built from run lengths, a fetched-byte queue and a fetch history.
module tb_zintack;
  logic clk = 1'b0;
  logic res;
  always #5 clk = ~clk;

  zintack_if bus ();
  zintack dut (.clk(clk), .res(res), .bus(bus));

  int n_vec = 0;
  int n_err = 0;

  // model state
  int         run;
  logic       m_intack, m_oe, m_spur, m_reti, m_retn, m_infetch, m_ret_st;
  logic [7:0] m_dout;
  int         m_depth;
  logic [7:0] exp_q[$];
  logic [7:0] hist_q[$];

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  task automatic model_clear();
    run = 0; m_intack = 0; m_oe = 0; m_spur = 0; m_reti = 0; m_retn = 0;
    m_infetch = 0; m_ret_st = 0; m_dout = 8'h00; m_depth = 0;
    exp_q.delete(); hist_q.delete();
  endtask

  // Applies the spec rules to the inputs that were present at the edge just taken.
  task automatic model_edge();
    logic prev_ack, rise, cond, fetch, dec;
    logic [7:0] b;
    if (res) begin
      model_clear();
      return;
    end
    cond     = !bus.m1_n && !bus.iorq_n;
    fetch    = !bus.m1_n && !bus.mreq_n && !bus.rd_n;
    prev_ack = m_intack;
    run      = cond ? ((run < 3) ? run + 1 : 3) : 0;
    m_intack = (run >= 2);
    rise     = m_intack && !prev_ack;
    m_oe     = m_intack || prev_ack;
    if (rise) m_dout = bus.im2vect;
    m_spur = rise && bus.int_n;

    m_reti = 0; m_retn = 0;
    if (exp_q.size() > 0) begin
      b = exp_q.pop_front();
      if (hist_q.size() > 0 && hist_q[$] == 8'hED) begin
        m_reti = (b == 8'h4D);
        m_retn = (b == 8'h45);
      end
      hist_q.push_back(b);
      if (hist_q.size() > 4) void'(hist_q.pop_front());
    end
    m_ret_st = (hist_q.size() > 0) && (hist_q[$] == 8'hED);

    if (m_infetch && bus.rd_n) exp_q.push_back(bus.din);
    if (fetch) m_infetch = 1;
    else if (bus.rd_n) m_infetch = 0;

    dec = m_reti || m_retn;
    if (rise && !dec) m_depth = (m_depth < 7) ? m_depth + 1 : 7;
    else if (dec && !rise) m_depth = (m_depth > 0) ? m_depth - 1 : 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_edge();
    chk("intack",  {7'd0, bus.intack},  {7'd0, m_intack});
    chk("dout",    bus.dout,            m_dout);
    chk("dout_oe", {7'd0, bus.dout_oe}, {7'd0, m_oe});
    chk("spur",    {7'd0, bus.spur},    {7'd0, m_spur});
    chk("reti",    {7'd0, bus.reti},    {7'd0, m_reti});
    chk("retn",    {7'd0, bus.retn},    {7'd0, m_retn});
    chk("depth",   {5'd0, bus.depth},   m_depth[7:0]);
    chk("insvc",   {7'd0, bus.insvc},   {7'd0, m_depth != 0});
    chk("ret_st",  {7'd0, bus.ret_st},  {7'd0, m_ret_st});
  endtask

  task automatic bus_idle();
    bus.m1_n = 1; bus.iorq_n = 1; bus.mreq_n = 1; bus.rd_n = 1;
  endtask

  task automatic idle(input int n);
    bus_idle();
    repeat (n) step();
  endtask

  task automatic inta(input int len, input logic [7:0] vec, input logic intn);
    bus.m1_n = 0; bus.iorq_n = 0; bus.im2vect = vec; bus.int_n = intn;
    repeat (len) step();
    bus_idle();
    bus.im2vect = 8'($urandom);
    step();
  endtask

  task automatic fetch(input logic [7:0] b);
    bus.m1_n = 0; bus.mreq_n = 0; bus.rd_n = 0; bus.din = b;
    step(); step();
    bus_idle();
    step();
    bus.din = 8'($urandom);
  endtask

  task automatic do_reset(input int n);
    res = 1;
    repeat (n) step();
    res = 0;
  endtask

  initial begin
    logic [7:0] pick[5];
    int d0;
    pick[0] = 8'hED; pick[1] = 8'h4D; pick[2] = 8'h45; pick[3] = 8'h00; pick[4] = 8'hED;
    model_clear();
    bus_idle();
    bus.din = 8'h00; bus.int_n = 1; bus.im2vect = 8'h00;
    res = 1;
    step(); step();
    res = 0;
    idle(2);

    // 5-clk INTA with vector FD
    inta(5, 8'hFD, 1'b0);
    idle(2);
    chk("depth_after_inta", {5'd0, bus.depth}, 8'd1);
    chk("dout_held", bus.dout, 8'hFD);
    // single-clk glitch must not acknowledge
    inta(1, 8'h11, 1'b0);
    idle(2);
    chk("depth_glitch", {5'd0, bus.depth}, 8'd1);

    // depth 2, then RETI and RETN
    inta(3, 8'h22, 1'b0);
    fetch(8'hED); fetch(8'h4D); idle(2);
    chk("depth_reti", {5'd0, bus.depth}, 8'd1);
    fetch(8'hED); fetch(8'hED); fetch(8'h45); idle(2);
    chk("depth_retn", {5'd0, bus.depth}, 8'd0);
    chk("insvc_zero", {7'd0, bus.insvc}, 8'd0);

    // broken prefix, then INTA between ED and 4D
    fetch(8'hED); fetch(8'h00); fetch(8'h4D); idle(1);
    fetch(8'hED); inta(3, 8'h33, 1'b0); fetch(8'h4D); idle(2);
    chk("depth_inta_between", {5'd0, bus.depth}, 8'd0);

    // spurious acknowledge, then saturation
    inta(3, 8'h44, 1'b1);
    do_reset(1);
    repeat (8) inta(3, 8'($urandom), 1'b0);
    idle(1);
    chk("depth_sat", {5'd0, bus.depth}, 8'd7);

    // RETI decoded on the same edge that intack rises
    inta(2, 8'h55, 1'b0); // still saturated, refill not needed
    do_reset(1);
    inta(3, 8'h56, 1'b0); inta(3, 8'h57, 1'b0);
    fetch(8'hED);
    d0 = bus.depth;
    bus.m1_n = 0; bus.mreq_n = 0; bus.rd_n = 0; bus.din = 8'h4D;
    step(); step();
    bus.mreq_n = 1; bus.rd_n = 1; bus.iorq_n = 0; bus.int_n = 0;
    step(); step(); step();
    bus_idle();
    step(); idle(1);
    chk("depth_coincide", {5'd0, bus.depth}, d0[7:0]);

    // reset during an active INTA, condition held through release
    bus.m1_n = 0; bus.iorq_n = 0; bus.im2vect = 8'h66; bus.int_n = 0;
    step(); step(); step();
    res = 1; step(); res = 0;
    chk("intack_reset", {7'd0, bus.intack}, 8'd0);
    step();
    chk("intack_requal1", {7'd0, bus.intack}, 8'd0);
    step();
    chk("intack_requal2", {7'd0, bus.intack}, 8'd1);
    idle(2);

    // random mix
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: inta($urandom_range(1, 5), 8'($urandom), 1'($urandom_range(0, 3) == 0));
        3, 4, 5, 6: fetch(($urandom_range(0, 3) == 0) ? 8'($urandom) : pick[$urandom_range(0, 4)]);
        7: idle($urandom_range(1, 3));
        8: begin
          bus.m1_n = 0; bus.mreq_n = 0; bus.rd_n = 0; bus.din = 8'hED;
          step();
          res = 1; step(); res = 0;
          bus_idle(); step();
        end
        default: begin
          bus.m1_n = 0; bus.iorq_n = 0; bus.im2vect = 8'($urandom);
          repeat ($urandom_range(1, 3)) step();
          res = 1; step(); res = 0;
          repeat ($urandom_range(0, 3)) step();
          bus_idle(); step();
        end
      endcase
    end
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
